shift_counter: RTL and testbench
================================

SHIFT_COUNTER -- requirements
Module: shift_counter

Interface
REQ-001 Parameter: WIDTH, default 8, count register width; the function is fully specified for WIDTH=8 only.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: count  output  WIDTH  registered one-hot shift-counter value.
REQ-005 Positional port order SHALL be (count, clk, reset) so positional instantiation binds correctly.
REQ-006 One clock; reset is asynchronous and active-high.

Function
REQ-007 count SHALL be driven directly from a register, with no combinational path from any input to count.
REQ-008 Internal state SHALL be count plus a 1-bit direction flag dir (LEFT=0, RIGHT=1).
REQ-009 LEFT, count != 8'b1000_0000: next count SHALL be count << 1; dir unchanged.
REQ-010 LEFT, count == 8'b1000_0000: next count SHALL be 8'b0100_0000; dir becomes RIGHT.
REQ-011 RIGHT, count != 8'b0000_0001: next count SHALL be count >> 1; dir unchanged.
REQ-012 RIGHT, count == 8'b0000_0001: next count SHALL be 8'b0000_0010; dir becomes LEFT.
REQ-013 The sequence SHALL be 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02,... (hex), with a period of 14 clocks; end values SHALL appear for exactly one cycle per bounce.
REQ-014 Illegal state recovery: if count is not one-hot (zero or multiple bits set), the next count SHALL be 8'b0000_0001 with dir LEFT.
REQ-015 Latency: each clock edge with reset low SHALL advance exactly one step; the counter has no enable and no hold state.

Reset
REQ-016 While reset=1, count SHALL be 8'b0000_0001 and dir LEFT, asynchronously and regardless of clk.
REQ-017 The first rising edge sampled with reset=0 SHALL produce count=8'b0000_0010.
REQ-018 Reset asserted mid-sequence, in either direction, SHALL immediately force the reset state; the sequence SHALL restart from 01 going left.
REQ-019 Before the first reset, count is unspecified; the block SHALL NOT rely on initial values.

Structure
REQ-020 A shared package SHALL hold: WIDTH default (8), RESET_VALUE (8'b0000_0001), TOP_VALUE (8'b1000_0000), BOTTOM_VALUE (8'b0000_0001), and the dir enum type {LEFT, RIGHT}.
REQ-021 The block SHALL consist of one sequential process for count/dir with async reset, plus one combinational next-state function including the one-hot check.
REQ-022 The block SHALL contain no sub-module; a one-hot checker function local to the module suffices.

Verification
REQ-023 Reset: clk period 10, reset high at t=50 for 15 time units -> count=00000001 at t=50 (asynchronous, before any edge) and while reset is high.
REQ-024 Full cycle: release reset, run 14 edges -> exact sequence 02,04,08,10,20,40,80,40,20,10,08,04,02,01, then 02 on edge 15.
REQ-025 Bounce points: 80 held exactly one cycle, followed by 40; 01 held exactly one cycle (not after reset), followed by 02.
REQ-026 Mid-operation reset: assert reset while count=20 in the RIGHT direction -> count=01 immediately; after release, next edge gives 02 (LEFT).
REQ-027 Illegal state: force count=8'b0000_0000 or 8'b0000_0011 and release -> next edge gives 01, then 02.
REQ-028 Invariant checker: on every cycle after reset, count SHALL be one-hot and $onehot(count) SHALL hold.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// Shared constants and direction type for the bouncing one-hot shift counter.
package shift_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic [DEFAULT_WIDTH-1:0] RESET_VALUE  = 8'b0000_0001;
    localparam logic [DEFAULT_WIDTH-1:0] TOP_VALUE    = 8'b1000_0000;
    localparam logic [DEFAULT_WIDTH-1:0] BOTTOM_VALUE = 8'b0000_0001;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/shift_counter.sv
// One-hot counter that walks a single set bit left to the top, bounces, walks
// right to the bottom, bounces again; non-one-hot states recover to reset.
module shift_counter
    import shift_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    output logic [WIDTH-1:0] count,
    input  logic             clk,
    input  logic             reset
);

    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP_VALUE);
    localparam logic [WIDTH-1:0] BOT_V = WIDTH'(BOTTOM_VALUE);

    dir_e             dir;
    dir_e             dir_nxt;
    logic [WIDTH-1:0] count_nxt;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= RST_V;
            dir   <= LEFT;
        end else begin
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        if (!is_onehot(count)) begin
            count_nxt = RST_V;
            dir_nxt   = LEFT;
        end else if (dir == LEFT) begin
            if (count == TOP_V) begin
                count_nxt = TOP_V >> 1;
                dir_nxt   = RIGHT;
            end else begin
                count_nxt = count << 1;
            end
        end else begin
            if (count == BOT_V) begin
                count_nxt = BOT_V << 1;
                dir_nxt   = LEFT;
            end else begin
                count_nxt = count >> 1;
            end
        end
    end

endmodule

// File: tb/tb_shift_counter.sv
// Directed bench for shift_counter: reset, full bounce cycle, mid-run reset,
// illegal-state recovery and a continuous one-hot monitor.
module tb_shift_counter;

    logic       clk;
    logic       reset;
    logic [7:0] count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  seq [15];

    shift_counter #(.WIDTH(8)) dut (
        .count (count),
        .clk   (clk),
        .reset (reset)
    );

    // Rising edges at 7, 17, 27, ... so reset transitions never coincide with one.
    initial begin
        clk = 1'b0;
        #2;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step_check(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        check(tag, count, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset)
            check("onehot", {7'd0, $onehot(count)}, 8'd1);
    end

    initial begin
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        reset = 1'b0;

        // Asynchronous reset between edges, then held across an edge.
        #50 reset = 1'b1;
        #1  check("reset_async", count, 8'h01);
        #7  check("reset_hold", count, 8'h01);
        #7  reset = 1'b0;
        mon_en = 1'b1;

        // Full period plus one: 14 edges return to 01, edge 15 gives 02.
        for (int i = 0; i < 15; i++)
            step_check($sformatf("seq[%0d]", i), seq[i]);

        // Walk 02 -> 80 -> back down to 20 travelling right.
        step_check("walk_04", 8'h04);
        step_check("walk_08", 8'h08);
        step_check("walk_10", 8'h10);
        step_check("walk_20L", 8'h20);
        step_check("walk_40", 8'h40);
        step_check("bounce_top", 8'h80);
        step_check("after_top", 8'h40);
        step_check("walk_20R", 8'h20);

        // Reset mid-sequence while moving right.
        #1 reset = 1'b1;
        #1 check("mid_reset", count, 8'h01);
        #2 reset = 1'b0;
        step_check("mid_rel_02", 8'h02);
        step_check("mid_rel_04", 8'h04);

        // Illegal state 00 recovers to 01 then continues left.
        mon_en = 1'b0;
        force dut.count = 8'h00;
        #1 release dut.count;
        step_check("illegal00_rec", 8'h01);
        step_check("illegal00_next", 8'h02);

        // Illegal state 03 (two bits) recovers the same way.
        force dut.count = 8'h03;
        #1 release dut.count;
        step_check("illegal03_rec", 8'h01);
        step_check("illegal03_next", 8'h02);
        mon_en = 1'b1;

        // Run past both bounces again; the monitor keeps checking one-hot.
        for (int i = 1; i < 15; i++)
            step_check($sformatf("rerun[%0d]", i), seq[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
